// File: rtl/acdc_multi.sv
// Time-multiplexed AC/DC splitter: per-channel DC tracks a rounded first-order IIR
// of 2^DIV-sample block means; AC is the saturated residual against the pre-update DC.
module acdc_multi #(
    parameter int N   = 18,
    parameter int CW  = 2,
    parameter int DIV = 4,
    parameter int IIR = 2
) (
    input  logic          nReset,
    input  logic          Clk,
    input  logic          InValid,
    input  logic [CW-1:0] InChan,
    input  logic [N-1:0]  Input,
    input  logic          Hold,
    input  logic          Load,
    input  logic [CW-1:0] LoadChan,
    input  logic [N-1:0]  LoadValue,
    output logic          OutValid,
    output logic [CW-1:0] OutChan,
    output logic [N-1:0]  AC,
    output logic [N-1:0]  DC,
    output logic          Clip,
    output logic          Update
);
    localparam int CH = 1 << CW;
    localparam int SW = N + DIV;

    logic signed [SW-1:0] sum [CH];
    logic [DIV-1:0]       cnt [CH];
    logic signed [N-1:0]  dc  [CH];

    logic signed [N-1:0]  dcCur;
    logic signed [N:0]    diff;
    logic [N-1:0]         acSat;
    logic                 clipNow;
    logic                 loadHit;
    logic                 blockEnd;
    logic signed [SW-1:0] sumNext;
    logic signed [N-1:0]  mean;
    logic signed [N:0]    inc;
    logic signed [N:0]    incShr;
    logic signed [N:0]    stepRaw;
    logic signed [N-1:0]  step;
    logic signed [N-1:0]  dcNew;

    always_comb begin
        dcCur   = dc[InChan];
        diff    = {Input[N-1], Input} - {dcCur[N-1], dcCur};
        acSat   = diff[N-1:0];
        clipNow = 1'b0;
        if (diff[N] != diff[N-1]) begin
            clipNow = 1'b1;
            acSat   = diff[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end

        loadHit  = Load && (LoadChan == InChan);
        blockEnd = InValid && !loadHit && (&cnt[InChan]);
        sumNext  = sum[InChan] + {{DIV{Input[N-1]}}, Input};
        // Top N bits of the exact block sum are the floor of the mean.
        mean     = sumNext[SW-1:DIV];

        inc     = {mean[N-1], mean} - {dcCur[N-1], dcCur};
        incShr  = inc >>> IIR;
        stepRaw = incShr + {{N{1'b0}}, inc[IIR-1]};
        step    = stepRaw[N-1:0];
        if (stepRaw == '0) begin
            if (inc[N])
                step = '1;
            else if (inc != '0)
                step = {{(N-1){1'b0}}, 1'b1};
        end
        dcNew = dcCur + step;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < CH; i++) begin
                sum[i] <= '0;
                cnt[i] <= '0;
                dc[i]  <= '0;
            end
            OutValid <= 1'b0;
            OutChan  <= '0;
            AC       <= '0;
            DC       <= '0;
            Clip     <= 1'b0;
            Update   <= 1'b0;
        end else begin
            if (InValid && !loadHit) begin
                if (blockEnd) begin
                    sum[InChan] <= '0;
                    cnt[InChan] <= '0;
                    if (!Hold)
                        dc[InChan] <= dcNew;
                end else begin
                    sum[InChan] <= sumNext;
                    cnt[InChan] <= cnt[InChan] + DIV'(1);
                end
            end
            if (Load) begin
                dc[LoadChan]  <= LoadValue;
                sum[LoadChan] <= '0;
                cnt[LoadChan] <= '0;
            end

            OutValid <= InValid;
            Update   <= blockEnd;
            if (InValid) begin
                OutChan <= InChan;
                AC      <= acSat;
                DC      <= dcCur;
                Clip    <= clipNow;
            end
        end
    end
endmodule

// File: tb/tb_acdc_multi.sv
// Scoreboard bench for acdc_multi: a behavioural per-channel model predicts each output
// record, plus directed checks of the DC trajectory, saturation, hold, load and reset.
module tb_acdc_multi;
    localparam int N    = 18;
    localparam int CW   = 2;
    localparam int DIV  = 4;
    localparam int IIR  = 2;
    localparam int CH   = 1 << CW;
    localparam int BLK  = 1 << DIV;
    localparam int MAXV = (1 << (N-1)) - 1;
    localparam int MINV = -(1 << (N-1));

    typedef struct packed {
        logic          v;
        logic [CW-1:0] ch;
        logic [N-1:0]  ac;
        logic [N-1:0]  dc;
        logic          clip;
        logic          upd;
    } outRec;

    logic          Clk = 1'b0;
    logic          nReset = 1'b0;
    logic          InValid = 1'b0;
    logic [CW-1:0] InChan = '0;
    logic [N-1:0]  Input = '0;
    logic          Hold = 1'b0;
    logic          Load = 1'b0;
    logic [CW-1:0] LoadChan = '0;
    logic [N-1:0]  LoadValue = '0;
    logic          OutValid;
    logic [CW-1:0] OutChan;
    logic [N-1:0]  AC;
    logic [N-1:0]  DC;
    logic          Clip;
    logic          Update;

    int cmpCount = 0;
    int failCount = 0;
    int mSum [CH];
    int mCnt [CH];
    int mDc  [CH];
    outRec sbq [$];

    acdc_multi #(.N(N), .CW(CW), .DIV(DIV), .IIR(IIR)) dut (
        .nReset(nReset), .Clk(Clk),
        .InValid(InValid), .InChan(InChan), .Input(Input),
        .Hold(Hold), .Load(Load), .LoadChan(LoadChan), .LoadValue(LoadValue),
        .OutValid(OutValid), .OutChan(OutChan), .AC(AC), .DC(DC),
        .Clip(Clip), .Update(Update)
    );

    always #5 Clk = ~Clk;

    task automatic clearModel();
        for (int i = 0; i < CH; i++) begin
            mSum[i] = 0;
            mCnt[i] = 0;
            mDc[i]  = 0;
        end
        sbq.delete();
    endtask

    // Drive one cycle, push the model's prediction, then pop it against what the DUT shows.
    task automatic applyStimulus(input logic v, input int ch, input int val, input logic hold,
                                 input logic ld, input int lch, input int lval,
                                 output outRec obs, output outRec exp);
        outRec e;
        int d, ac, dcur, mean, inc, step;
        logic clip;
        InValid   = v;
        InChan    = ch[CW-1:0];
        Input     = val[N-1:0];
        Hold      = hold;
        Load      = ld;
        LoadChan  = lch[CW-1:0];
        LoadValue = lval[N-1:0];

        e = '0;
        e.v = v;
        if (v) begin
            dcur = mDc[ch];
            d    = val - dcur;
            clip = 1'b1;
            if (d > MAXV) ac = MAXV;
            else if (d < MINV) ac = MINV;
            else begin
                ac   = d;
                clip = 1'b0;
            end
            e.ch   = ch[CW-1:0];
            e.ac   = ac[N-1:0];
            e.dc   = dcur[N-1:0];
            e.clip = clip;
            if (!(ld && lch == ch)) begin
                mSum[ch] += val;
                if (mCnt[ch] == BLK - 1) begin
                    e.upd = 1'b1;
                    mean = mSum[ch] >>> DIV;
                    mSum[ch] = 0;
                    mCnt[ch] = 0;
                    if (!hold) begin
                        inc  = mean - dcur;
                        step = (inc + (1 << (IIR-1))) >>> IIR;
                        if (step == 0) step = (inc > 0) ? 1 : ((inc < 0) ? -1 : 0);
                        mDc[ch] = dcur + step;
                    end
                end else begin
                    mCnt[ch] += 1;
                end
            end
        end
        if (ld) begin
            mDc[lch]  = lval;
            mSum[lch] = 0;
            mCnt[lch] = 0;
        end
        sbq.push_back(e);

        @(posedge Clk);
        #1;
        obs = '0;
        obs.v = OutValid;
        obs.upd = Update;
        if (OutValid) begin
            obs.ch   = OutChan;
            obs.ac   = AC;
            obs.dc   = DC;
            obs.clip = Clip;
        end
        exp = sbq.pop_front();
    endtask

    task automatic goIdle();
        InValid = 1'b0;
        Load    = 1'b0;
        Hold    = 1'b0;
    endtask

    task automatic test_reset();
        logic [2*N+CW+3-1:0] all;
        nReset = 1'b0;
        clearModel();
        #12;
        all = {OutValid, OutChan, AC, DC, Clip, Update};
        cmpCount++;
        if (all !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got %h want 0", all);
        end
        @(negedge Clk);
        nReset = 1'b1;
    endtask

    task automatic test_converge();
        outRec obs, exp, last0, last1;
        int upd0 = 0, upd1 = 0;
        for (int i = 0; i < 20*BLK; i++) begin
            applyStimulus(1'b1, 0, 100, 1'b0, 1'b0, 0, 0, obs, exp);
            cmpCount++;
            if (obs !== exp) begin failCount++; $display("[TB] FAIL conv_sb0: got %h want %h", obs, exp); end
            if (i == BLK || i == 2*BLK) begin
                cmpCount++;
                if ($signed(obs.dc) !== ((i == BLK) ? 25 : 44)) begin
                    failCount++;
                    $display("[TB] FAIL conv_dcstep: got %0d want %0d", $signed(obs.dc), (i == BLK) ? 25 : 44);
                end
            end
            upd0 += int'(obs.upd);
            last0 = obs;
            applyStimulus(1'b1, 1, -100, 1'b0, 1'b0, 0, 0, obs, exp);
            cmpCount++;
            if (obs !== exp) begin failCount++; $display("[TB] FAIL conv_sb1: got %h want %h", obs, exp); end
            upd1 += int'(obs.upd);
            last1 = obs;
        end
        goIdle();
        cmpCount++;
        if ($signed(last0.dc) !== 100 || $signed(last0.ac) !== 0) begin
            failCount++;
            $display("[TB] FAIL conv_final0: got dc=%0d ac=%0d want dc=100 ac=0", $signed(last0.dc), $signed(last0.ac));
        end
        cmpCount++;
        if ($signed(last1.dc) !== -100 || $signed(last1.ac) !== 0) begin
            failCount++;
            $display("[TB] FAIL conv_final1: got dc=%0d ac=%0d want dc=-100 ac=0", $signed(last1.dc), $signed(last1.ac));
        end
        cmpCount++;
        if (upd0 != 20 || upd1 != 20) begin
            failCount++;
            $display("[TB] FAIL conv_updates: got %0d/%0d want 20/20", upd0, upd1);
        end
    endtask

    task automatic test_nudge();
        outRec obs, exp;
        int startDc [2] = '{99, 101};
        for (int r = 0; r < 2; r++) begin
            applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 0, startDc[r], obs, exp);
            cmpCount++;
            if (obs !== exp) begin failCount++; $display("[TB] FAIL nudge_load: got %h want %h", obs, exp); end
            for (int i = 0; i <= BLK; i++) begin
                applyStimulus(1'b1, 0, 100, 1'b0, 1'b0, 0, 0, obs, exp);
                cmpCount++;
                if (obs !== exp) begin failCount++; $display("[TB] FAIL nudge_sb: got %h want %h", obs, exp); end
            end
            cmpCount++;
            if ($signed(obs.dc) !== 100 || $signed(obs.ac) !== 0) begin
                failCount++;
                $display("[TB] FAIL nudge_dc: got dc=%0d ac=%0d want dc=100 ac=0", $signed(obs.dc), $signed(obs.ac));
            end
        end
        goIdle();
    endtask

    task automatic test_saturation();
        outRec obs, exp;
        int ldv [4] = '{MINV, MAXV, MAXV, -1};
        int inv [4] = '{MAXV, MINV, MAXV, MAXV - 1};
        int wac [4] = '{MAXV, MINV, 0, MAXV};
        logic wclip [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 2, 0, 1'b0, 1'b1, 2, ldv[k], obs, exp);
            applyStimulus(1'b1, 2, inv[k], 1'b0, 1'b0, 0, 0, obs, exp);
            cmpCount++;
            if (obs !== exp) begin failCount++; $display("[TB] FAIL sat_sb: got %h want %h", obs, exp); end
            cmpCount++;
            if ($signed(obs.ac) !== wac[k] || obs.clip !== wclip[k]) begin
                failCount++;
                $display("[TB] FAIL sat_ac%0d: got ac=%0d clip=%0b want ac=%0d clip=%0b",
                         k, $signed(obs.ac), obs.clip, wac[k], wclip[k]);
            end
        end
        goIdle();
    endtask

    task automatic test_hold();
        outRec obs, exp;
        int upd = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 0, 500, 1'b1, 1'b0, 0, 0, obs, exp);
            cmpCount++;
            if (obs !== exp) begin failCount++; $display("[TB] FAIL hold_sb: got %h want %h", obs, exp); end
            cmpCount++;
            if ($signed(obs.dc) !== 100 || $signed(obs.ac) !== 400) begin
                failCount++;
                $display("[TB] FAIL hold_frozen: got dc=%0d ac=%0d want dc=100 ac=400", $signed(obs.dc), $signed(obs.ac));
            end
            upd += int'(obs.upd);
        end
        cmpCount++;
        if (upd != 4) begin failCount++; $display("[TB] FAIL hold_updates: got %0d want 4", upd); end
        for (int i = 0; i < 32*BLK; i++) begin
            applyStimulus(1'b1, 0, 500, 1'b0, 1'b0, 0, 0, obs, exp);
            cmpCount++;
            if (obs !== exp) begin failCount++; $display("[TB] FAIL release_sb: got %h want %h", obs, exp); end
        end
        cmpCount++;
        if ($signed(obs.dc) !== 500 || $signed(obs.ac) !== 0) begin
            failCount++;
            $display("[TB] FAIL release_dc: got dc=%0d ac=%0d want dc=500 ac=0", $signed(obs.dc), $signed(obs.ac));
        end
        goIdle();
    endtask

    task automatic test_load_collision();
        outRec obs, exp;
        applyStimulus(1'b0, 1, 0, 1'b0, 1'b1, 1, 0, obs, exp);
        applyStimulus(1'b1, 1, 50, 1'b0, 1'b1, 1, 7, obs, exp);
        cmpCount++;
        if (obs !== exp) begin failCount++; $display("[TB] FAIL coll_sb: got %h want %h", obs, exp); end
        cmpCount++;
        if ($signed(obs.ac) !== 50 || $signed(obs.dc) !== 0 || obs.upd !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL coll_olddc: got ac=%0d dc=%0d upd=%0b want ac=50 dc=0 upd=0",
                     $signed(obs.ac), $signed(obs.dc), obs.upd);
        end
        for (int j = 0; j < BLK; j++) begin
            applyStimulus(1'b1, 1, 50, 1'b0, (j == 0), 3, 5, obs, exp);
            cmpCount++;
            if (obs !== exp) begin failCount++; $display("[TB] FAIL coll_after_sb: got %h want %h", obs, exp); end
            cmpCount++;
            if ($signed(obs.dc) !== 7 || obs.upd !== (j == BLK - 1)) begin
                failCount++;
                $display("[TB] FAIL coll_restart%0d: got dc=%0d upd=%0b want dc=7 upd=%0b",
                         j, $signed(obs.dc), obs.upd, (j == BLK - 1));
            end
        end
        applyStimulus(1'b1, 3, 5, 1'b0, 1'b0, 0, 0, obs, exp);
        cmpCount++;
        if (obs !== exp || $signed(obs.dc) !== 5) begin
            failCount++;
            $display("[TB] FAIL coll_otherchan: got %h want %h (dc 5)", obs, exp);
        end
        goIdle();
    endtask

    task automatic test_reset_midblock();
        outRec obs, exp;
        logic [2*N+CW+3-1:0] all;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 3, 40, 1'b0, 1'b0, 0, 0, obs, exp);
            cmpCount++;
            if (obs !== exp) begin failCount++; $display("[TB] FAIL midrst_pre_sb: got %h want %h", obs, exp); end
        end
        goIdle();
        #1;
        nReset = 1'b0;
        #1;
        all = {OutValid, OutChan, AC, DC, Clip, Update};
        cmpCount++;
        if (all !== '0) begin failCount++; $display("[TB] FAIL midrst_outputs: got %h want 0", all); end
        clearModel();
        @(negedge Clk);
        nReset = 1'b1;
        for (int i = 0; i <= BLK; i++) begin
            applyStimulus(1'b1, 3, 40, 1'b0, 1'b0, 0, 0, obs, exp);
            cmpCount++;
            if (obs !== exp) begin failCount++; $display("[TB] FAIL midrst_post_sb: got %h want %h", obs, exp); end
        end
        cmpCount++;
        if ($signed(obs.dc) !== 10) begin
            failCount++;
            $display("[TB] FAIL midrst_dc: got %0d want 10", $signed(obs.dc));
        end
        goIdle();
    endtask

    initial begin
        test_reset();
        test_converge();
        test_nudge();
        test_saturation();
        test_hold();
        test_load_collision();
        test_reset_midblock();
        repeat (2) @(posedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end
endmodule
